// File: rtl/key_search_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_search_pkg : shared types and partition helpers for the RC4 key search
// Revision: 1.0
// ---------------------------------------------------------------------------
package key_search_pkg;

    typedef logic [63:0] ks_u64_t;

    typedef enum logic [2:0] {
        KS_IDLE      = 3'd0,
        KS_LAUNCH    = 3'd1,
        KS_RUN       = 3'd2,
        KS_FOUND     = 3'd3,
        KS_EXHAUSTED = 3'd4
    } ks_state_t;

    function automatic int cidx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic ks_u64_t slice_base(input int i, input ks_u64_t key_space,
                                           input int core_count);
        return ks_u64_t'(i) * (key_space / ks_u64_t'(core_count));
    endfunction

    // The last slice runs to the end of the key space, absorbing the remainder.
    function automatic ks_u64_t slice_limit(input int i, input ks_u64_t key_space,
                                            input int core_count);
        if (i == core_count - 1)
            return key_space;
        return ks_u64_t'(i + 1) * (key_space / ks_u64_t'(core_count));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_set_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lowest_set_encoder : index of the lowest set bit of a vector, plus any-set flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module lowest_set_encoder
    import key_search_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = cidx_w(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_index = '0;
        o_any   = |i_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i])
                o_index = IW'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_search_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_search_controller : launches, arbitrates and stops a bank of RC4 cores
// Revision: 1.0
// ---------------------------------------------------------------------------
module key_search_controller
    import key_search_pkg::*;
#(
    parameter  int      CORE_COUNT = 8,
    parameter  int      KEY_WIDTH  = 24,
    parameter  ks_u64_t KEY_SPACE  = 64'd8388608,
    parameter  int      CYC_WIDTH  = 32,
    localparam int      CIDX_W     = cidx_w(CORE_COUNT)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [CIDX_W-1:0]               view_sel,
    input  logic [CORE_COUNT-1:0]           core_done,
    input  logic [CORE_COUNT-1:0]           core_invalid,
    input  logic [CORE_COUNT*KEY_WIDTH-1:0] core_key,
    output logic [CORE_COUNT-1:0]           core_start,
    output logic [CORE_COUNT*KEY_WIDTH-1:0] core_base,
    output logic [CORE_COUNT*KEY_WIDTH-1:0] core_limit,
    output logic                            stop,
    output logic                            found,
    output logic                            exhausted,
    output logic [KEY_WIDTH-1:0]            found_key,
    output logic [CIDX_W-1:0]               found_core,
    output logic [CYC_WIDTH-1:0]            busy_cycles,
    output logic [CIDX_W-1:0]               disp_core
);

    ks_state_t              r_state;
    ks_state_t              w_state_nxt;
    logic [CORE_COUNT-1:0]  r_inv_mask;
    logic                   r_found;
    logic                   r_exhausted;
    logic [KEY_WIDTH-1:0]   r_found_key;
    logic [CIDX_W-1:0]      r_found_core;
    logic [CYC_WIDTH-1:0]   r_busy;
    logic [CIDX_W-1:0]      r_disp_core;

    logic [CORE_COUNT-1:0]  w_eligible;
    logic [CORE_COUNT-1:0]  w_inv_next;
    logic                   w_all_inv;
    logic [CIDX_W-1:0]      w_idx;
    logic                   w_any;
    logic [KEY_WIDTH-1:0]   w_sel_key;
    logic [CORE_COUNT-1:0]  w_core_start;

    generate
        for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_part
            assign core_base[gi*KEY_WIDTH +: KEY_WIDTH] =
                KEY_WIDTH'(slice_base(gi, KEY_SPACE, CORE_COUNT));
            assign core_limit[gi*KEY_WIDTH +: KEY_WIDTH] =
                KEY_WIDTH'(slice_limit(gi, KEY_SPACE, CORE_COUNT));
        end
    endgenerate

    // Eligibility uses the mask from earlier cycles, so a core whose invalid
    // first appears alongside its done still counts as a find.
    assign w_eligible = core_done & ~r_inv_mask;
    assign w_inv_next = r_inv_mask | core_invalid;
    assign w_all_inv  = &w_inv_next;

    lowest_set_encoder #(
        .N (CORE_COUNT)
    ) u_enc (
        .i_vec   (w_eligible),
        .o_index (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_key = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (w_idx == CIDX_W'(i))
                w_sel_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= KS_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_core_start = '0;
        case (r_state)
            KS_IDLE: begin
                if (start)
                    w_state_nxt = KS_LAUNCH;
            end
            KS_LAUNCH: begin
                w_core_start = '1;
                w_state_nxt  = KS_RUN;
            end
            KS_RUN: begin
                if (w_any)
                    w_state_nxt = KS_FOUND;
                else if (w_all_inv)
                    w_state_nxt = KS_EXHAUSTED;
            end
            KS_FOUND, KS_EXHAUSTED: begin
                if (start)
                    w_state_nxt = KS_LAUNCH;
            end
            default: w_state_nxt = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inv_mask   <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_found_key  <= '0;
            r_found_core <= '0;
            r_busy       <= '0;
            r_disp_core  <= '0;
        end else begin
            r_disp_core <= r_found ? r_found_core : view_sel;
            if (r_state == KS_LAUNCH) begin
                r_inv_mask   <= '0;
                r_found      <= 1'b0;
                r_exhausted  <= 1'b0;
                r_found_key  <= '0;
                r_found_core <= '0;
                r_busy       <= '0;
            end else if (r_state == KS_RUN) begin
                r_inv_mask <= w_inv_next;
                if (r_busy != {CYC_WIDTH{1'b1}})
                    r_busy <= r_busy + CYC_WIDTH'(1);
                if (w_any) begin
                    r_found      <= 1'b1;
                    r_found_core <= w_idx;
                    r_found_key  <= w_sel_key;
                end else if (w_all_inv) begin
                    r_exhausted <= 1'b1;
                end
            end
        end
    end

    assign core_start  = w_core_start;
    assign stop        = (r_state == KS_FOUND) || (r_state == KS_EXHAUSTED);
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign found_key   = r_found_key;
    assign found_core  = r_found_core;
    assign busy_cycles = r_busy;
    assign disp_core   = r_disp_core;

endmodule
`default_nettype wire
